// File: rtl/redstone_pkg.sv
// rtl/redstone_pkg.sv - shared state enum, default parameters and widths for tick_scheduler
package redstone_pkg;

    localparam int DEF_NUM_INPUTS    = 8;
    localparam int DEF_NUM_OUTPUTS   = 8;
    localparam int DEF_SETTLE_CYCLES = 2;
    localparam int DEF_TICK_DIV      = 100;
    localparam int TICK_CNT_W        = 32;
    localparam int STEP_CNT_W        = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_APPLY,
        ST_PULSE,
        ST_SETTLE,
        ST_CAPTURE
    } state_e;

    // One tick can never be shorter than APPLY + PULSE + SETTLE + CAPTURE,
    // so the run-mode pulse spacing is clamped to that.
    function automatic int run_interval(input int tick_div, input int settle_cycles);
        int min_len;
        min_len = settle_cycles + 3;
        return (tick_div > min_len) ? tick_div : min_len;
    endfunction

endpackage

// File: rtl/tick_divider.sv
// rtl/tick_divider.sv - run-mode interval counter, reloaded on each tick pulse
// Ports:
//   i_clk, i_rst  clock and synchronous active-high reset
//   i_load        reload the counter with LOAD_VAL (asserted during PULSE)
//   o_expired     counter at zero: the next cycle may start a new APPLY
module tick_divider #(
    parameter int LOAD_VAL = 97,
    parameter int CNT_W    = 7
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_load,
    output logic o_expired
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_load) begin
            cnt_d = CNT_W'(LOAD_VAL);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_expired = (cnt_q == '0);

endmodule

// File: rtl/tick_scheduler.sv
// rtl/tick_scheduler.sv - tick sequencer driving a compiled circuit (apply/pulse/settle/capture)
// Ports:
//   i_clk, i_rst                              clock, synchronous active-high reset
//   i_run                                     level, free-running ticks while high
//   i_step_valid/o_step_ready/i_step_count    request N single-step ticks
//   i_in_valid/o_in_ready/i_in_data           host input-vector update (one-entry buffer)
//   o_circ_in                                 vector applied to circuit inputs
//   o_tick                                    one-cycle tick pulse
//   i_circ_out                                combinational circuit outputs
//   o_out_valid/i_out_ready/o_out_data        per-tick output snapshot
//   o_tick_count, o_busy                      ticks since reset, FSM not idle
module tick_scheduler
    import redstone_pkg::*;
#(
    parameter int NUM_INPUTS    = DEF_NUM_INPUTS,
    parameter int NUM_OUTPUTS   = DEF_NUM_OUTPUTS,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int TICK_DIV      = DEF_TICK_DIV
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_run,
    input  logic                   i_step_valid,
    output logic                   o_step_ready,
    input  logic [STEP_CNT_W-1:0]  i_step_count,
    input  logic                   i_in_valid,
    output logic                   o_in_ready,
    input  logic [NUM_INPUTS-1:0]  i_in_data,
    output logic [NUM_INPUTS-1:0]  o_circ_in,
    output logic                   o_tick,
    input  logic [NUM_OUTPUTS-1:0] i_circ_out,
    output logic                   o_out_valid,
    input  logic                   i_out_ready,
    output logic [NUM_OUTPUTS-1:0] o_out_data,
    output logic [TICK_CNT_W-1:0]  o_tick_count,
    output logic                   o_busy
);

    localparam int INTERVAL = run_interval(TICK_DIV, SETTLE_CYCLES);
    // Loaded during PULSE; reaching zero lets IDLE/CAPTURE enter APPLY so the
    // following PULSE lands exactly INTERVAL cycles after the previous one.
    localparam int DIV_LOAD = INTERVAL - 3;
    localparam int DIV_W    = $clog2(DIV_LOAD + 2);
    localparam int SET_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);

    state_e                  state_q, state_d;
    logic [STEP_CNT_W-1:0]   remaining_q, remaining_d;
    logic                    step_mode_q, step_mode_d;
    logic [SET_W-1:0]        settle_cnt_q, settle_cnt_d;
    logic                    pend_valid_q, pend_valid_d;
    logic [NUM_INPUTS-1:0]   pend_data_q, pend_data_d;
    logic [NUM_INPUTS-1:0]   circ_in_q, circ_in_d;
    logic                    out_valid_q, out_valid_d;
    logic [NUM_OUTPUTS-1:0]  out_data_q, out_data_d;
    logic [TICK_CNT_W-1:0]   tick_count_q, tick_count_d;
    logic                    capture_fire;
    logic                    div_expired;
    logic                    in_accept;

    tick_divider #(
        .LOAD_VAL (DIV_LOAD),
        .CNT_W    (DIV_W)
    ) u_divider (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_load    (state_q == ST_PULSE),
        .o_expired (div_expired)
    );

    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        step_mode_d  = step_mode_q;
        settle_cnt_d = settle_cnt_q;
        capture_fire = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Run mode owns the FSM while i_run is high; steps are not ready then.
                if (i_run) begin
                    if (div_expired) begin
                        step_mode_d = 1'b0;
                        state_d     = ST_APPLY;
                    end
                end else if (i_step_valid && (i_step_count != '0)) begin
                    remaining_d = i_step_count;
                    step_mode_d = 1'b1;
                    state_d     = ST_APPLY;
                end
            end
            ST_APPLY: begin
                state_d = ST_PULSE;
            end
            ST_PULSE: begin
                settle_cnt_d = '0;
                state_d      = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (settle_cnt_q == SET_LAST) begin
                    state_d = ST_CAPTURE;
                end else begin
                    settle_cnt_d = settle_cnt_q + 1'b1;
                end
            end
            ST_CAPTURE: begin
                // Stall here while the previous snapshot is still unconsumed.
                if (!out_valid_q || i_out_ready) begin
                    capture_fire = 1'b1;
                    if (step_mode_q) begin
                        remaining_d = remaining_q - 1'b1;
                        state_d     = (remaining_q != 16'd1) ? ST_APPLY : ST_IDLE;
                    end else begin
                        state_d = (i_run && div_expired) ? ST_APPLY : ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        in_accept    = i_in_valid && !pend_valid_q;
        pend_valid_d = pend_valid_q;
        pend_data_d  = pend_data_q;
        circ_in_d    = circ_in_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        tick_count_d = tick_count_q;
        if ((state_q == ST_APPLY) && pend_valid_q) begin
            circ_in_d    = pend_data_q;
            pend_valid_d = 1'b0;
        end
        // A same-cycle accept wins over the APPLY clear.
        if (in_accept) begin
            pend_valid_d = 1'b1;
            pend_data_d  = i_in_data;
        end
        if (i_out_ready) begin
            out_valid_d = 1'b0;
        end
        if (capture_fire) begin
            out_valid_d = 1'b1;
            out_data_d  = i_circ_out;
        end
        if (state_q == ST_PULSE) begin
            tick_count_d = tick_count_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            remaining_q  <= '0;
            step_mode_q  <= 1'b0;
            settle_cnt_q <= '0;
            pend_valid_q <= 1'b0;
            pend_data_q  <= '0;
            circ_in_q    <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            tick_count_q <= '0;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            step_mode_q  <= step_mode_d;
            settle_cnt_q <= settle_cnt_d;
            pend_valid_q <= pend_valid_d;
            pend_data_q  <= pend_data_d;
            circ_in_q    <= circ_in_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            tick_count_q <= tick_count_d;
        end
    end

    assign o_tick       = (state_q == ST_PULSE);
    assign o_busy       = (state_q != ST_IDLE);
    assign o_step_ready = (state_q == ST_IDLE) && !i_run;
    assign o_in_ready   = !pend_valid_q;
    assign o_circ_in    = circ_in_q;
    assign o_out_valid  = out_valid_q;
    assign o_out_data   = out_data_q;
    assign o_tick_count = tick_count_q;

endmodule

// File: tb/tb_tick_scheduler.sv
// tb/tb_tick_scheduler.sv - directed self-checking bench for tick_scheduler
module tb_tick_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        run = 1'b0;
    logic        step_valid = 1'b0;
    logic        step_ready;
    logic [15:0] step_count = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = '0;
    logic [7:0]  circ_in;
    logic        tick;
    logic [7:0]  circ_out;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_data;
    logic [31:0] tick_count;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    // Stand-in for the compiled circuit: outputs are the inverted inputs.
    assign circ_out = ~circ_in;

    always #5 clk = ~clk;

    tick_scheduler dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_run        (run),
        .i_step_valid (step_valid),
        .o_step_ready (step_ready),
        .i_step_count (step_count),
        .i_in_valid   (in_valid),
        .o_in_ready   (in_ready),
        .i_in_data    (in_data),
        .o_circ_in    (circ_in),
        .o_tick       (tick),
        .i_circ_out   (circ_out),
        .o_out_valid  (out_valid),
        .i_out_ready  (out_ready),
        .o_out_data   (out_data),
        .o_tick_count (tick_count),
        .o_busy       (busy)
    );

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    task automatic issue_step(input logic [15:0] n);
        step_valid = 1'b1;
        step_count = n;
        cyc();
        step_valid = 1'b0;
        step_count = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc();
        cyc();
        n_vec++; if (tick !== 1'b0) begin n_err++; $display("FAIL reset_tick got %b exp 0", tick); end
        n_vec++; if (circ_in !== 8'h00) begin n_err++; $display("FAIL reset_circ_in got %h exp 00", circ_in); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        n_vec++; if (out_data !== 8'h00) begin n_err++; $display("FAIL reset_out_data got %h exp 00", out_data); end
        n_vec++; if (tick_count !== 32'd0) begin n_err++; $display("FAIL reset_tick_count got %0d exp 0", tick_count); end
        rst = 1'b0;
        cyc();
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        n_vec++; if (step_ready !== 1'b1) begin n_err++; $display("FAIL reset_step_ready got %b exp 1", step_ready); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", busy); end
    endtask

    task automatic test_step();
        int ticks;
        int xfers;
        int t_at[3];
        logic [7:0] circ_first;
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hA5;
        cyc();
        in_valid = 1'b0;
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL step_pending_in_ready got %b exp 0", in_ready); end
        n_vec++; if (circ_in !== 8'h00) begin n_err++; $display("FAIL step_circ_before_apply got %h exp 00", circ_in); end
        issue_step(16'd3);
        ticks = 0;
        xfers = 0;
        circ_first = 8'hxx;
        for (int k = 0; k < 30; k++) begin
            if (tick) begin
                if (ticks == 0) circ_first = circ_in;
                if (ticks < 3) t_at[ticks] = k;
                ticks++;
            end
            if (out_valid && out_ready) xfers++;
            cyc();
        end
        n_vec++; if (circ_first !== 8'hA5) begin n_err++; $display("FAIL step_circ_at_tick got %h exp a5", circ_first); end
        n_vec++; if (ticks !== 3) begin n_err++; $display("FAIL step_ticks got %0d exp 3", ticks); end
        n_vec++; if (t_at[1] - t_at[0] !== 5) begin n_err++; $display("FAIL step_spacing1 got %0d exp 5", t_at[1] - t_at[0]); end
        n_vec++; if (t_at[2] - t_at[1] !== 5) begin n_err++; $display("FAIL step_spacing2 got %0d exp 5", t_at[2] - t_at[1]); end
        n_vec++; if (xfers !== 3) begin n_err++; $display("FAIL step_out_xfers got %0d exp 3", xfers); end
        n_vec++; if (tick_count !== 32'd3) begin n_err++; $display("FAIL step_tick_count got %0d exp 3", tick_count); end
        n_vec++; if (out_data !== 8'h5A) begin n_err++; $display("FAIL step_out_data got %h exp 5a", out_data); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL step_busy_end got %b exp 0", busy); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL step_in_ready_end got %b exp 1", in_ready); end
    endtask

    task automatic test_pending();
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h11;
        cyc();
        in_data  = 8'h22;
        cyc();
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL pend_full_in_ready got %b exp 0", in_ready); end
        in_valid = 1'b0;
        issue_step(16'd1);
        repeat (10) cyc();
        n_vec++; if (circ_in !== 8'h11) begin n_err++; $display("FAIL pend_first_applied got %h exp 11", circ_in); end
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        issue_step(16'd1);
        repeat (10) cyc();
        n_vec++; if (circ_in !== 8'h22) begin n_err++; $display("FAIL pend_second_applied got %h exp 22", circ_in); end
        n_vec++; if (out_data !== 8'hDD) begin n_err++; $display("FAIL pend_out_data got %h exp dd", out_data); end
    endtask

    task automatic test_backpressure();
        int ticks;
        do_reset();
        out_ready = 1'b0;
        // Leave one snapshot unconsumed so the next tick stalls in CAPTURE.
        issue_step(16'd1);
        repeat (10) cyc();
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_prefill_valid got %b exp 1", out_valid); end
        issue_step(16'd2);
        ticks = 0;
        for (int k = 0; k < 14; k++) begin
            if (tick) ticks++;
            cyc();
        end
        n_vec++; if (ticks !== 1) begin n_err++; $display("FAIL bp_ticks_stalled got %0d exp 1", ticks); end
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL bp_busy_stalled got %b exp 1", busy); end
        n_vec++; if (tick_count !== 32'd2) begin n_err++; $display("FAIL bp_count_stalled got %0d exp 2", tick_count); end
        out_ready = 1'b1;
        for (int k = 0; k < 14; k++) begin
            if (tick) ticks++;
            cyc();
        end
        n_vec++; if (ticks !== 2) begin n_err++; $display("FAIL bp_ticks_released got %0d exp 2", ticks); end
        n_vec++; if (tick_count !== 32'd3) begin n_err++; $display("FAIL bp_count_released got %0d exp 3", tick_count); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL bp_busy_end got %b exp 0", busy); end
        n_vec++; if (out_data !== 8'hFF) begin n_err++; $display("FAIL bp_out_data got %h exp ff", out_data); end
    endtask

    task automatic test_run();
        int t_at[16];
        int ticks;
        int late;
        logic seen;
        do_reset();
        out_ready = 1'b1;
        run = 1'b1;
        ticks = 0;
        for (int k = 0; k < 1000; k++) begin
            cyc();
            if (tick) begin
                if (ticks < 16) t_at[ticks] = k;
                ticks++;
            end
            if (k == 50) begin
                n_vec++; if (step_ready !== 1'b0) begin n_err++; $display("FAIL run_step_ready got %b exp 0", step_ready); end
            end
        end
        n_vec++; if (ticks !== 10) begin n_err++; $display("FAIL run_tick_total got %0d exp 10", ticks); end
        n_vec++; if (t_at[0] !== 1) begin n_err++; $display("FAIL run_first_pulse got %0d exp 1", t_at[0]); end
        for (int i = 1; i < 10; i++) begin
            n_vec++;
            if (t_at[i] - t_at[i-1] !== 100) begin
                n_err++; $display("FAIL run_spacing_%0d got %0d exp 100", i, t_at[i] - t_at[i-1]);
            end
        end
        seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            cyc();
            if (tick) seen = 1'b1;
        end
        n_vec++; if (seen !== 1'b1) begin n_err++; $display("FAIL run_eleventh_pulse got %b exp 1", seen); end
        cyc();
        run = 1'b0;
        cyc();
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL run_drop_settle_busy got %b exp 1", busy); end
        cyc();
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL run_drop_capture_busy got %b exp 1", busy); end
        cyc();
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL run_drop_idle_busy got %b exp 0", busy); end
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL run_drop_out_valid got %b exp 1", out_valid); end
        late = 0;
        for (int k = 0; k < 150; k++) begin
            if (tick) late++;
            cyc();
        end
        n_vec++; if (late !== 0) begin n_err++; $display("FAIL run_after_stop_ticks got %0d exp 0", late); end
        n_vec++; if (tick_count !== 32'd11) begin n_err++; $display("FAIL run_tick_count got %0d exp 11", tick_count); end
    endtask

    task automatic test_zero_step();
        int ticks;
        do_reset();
        issue_step(16'd0);
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL zero_busy got %b exp 0", busy); end
        n_vec++; if (step_ready !== 1'b1) begin n_err++; $display("FAIL zero_step_ready got %b exp 1", step_ready); end
        ticks = 0;
        for (int k = 0; k < 10; k++) begin
            if (tick) ticks++;
            cyc();
        end
        n_vec++; if (ticks !== 0) begin n_err++; $display("FAIL zero_ticks got %0d exp 0", ticks); end
        n_vec++; if (tick_count !== 32'd0) begin n_err++; $display("FAIL zero_tick_count got %0d exp 0", tick_count); end
    endtask

    task automatic test_wrap();
        do_reset();
        out_ready = 1'b1;
        force dut.tick_count_q = 32'hFFFF_FFFF;
        cyc();
        release dut.tick_count_q;
        cyc();
        n_vec++; if (tick_count !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL wrap_preset got %h exp ffffffff", tick_count); end
        issue_step(16'd1);
        repeat (8) cyc();
        n_vec++; if (tick_count !== 32'd0) begin n_err++; $display("FAIL wrap_result got %h exp 00000000", tick_count); end
    endtask

    task automatic test_reset_in_pulse();
        logic seen;
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h3C;
        cyc();
        in_valid = 1'b0;
        issue_step(16'd3);
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            if (tick) seen = 1'b1;
            else cyc();
        end
        n_vec++; if (seen !== 1'b1) begin n_err++; $display("FAIL rp_pulse_seen got %b exp 1", seen); end
        rst = 1'b1;
        cyc();
        n_vec++; if (tick !== 1'b0) begin n_err++; $display("FAIL rp_tick got %b exp 0", tick); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rp_busy got %b exp 0", busy); end
        n_vec++; if (circ_in !== 8'h00) begin n_err++; $display("FAIL rp_circ_in got %h exp 00", circ_in); end
        n_vec++; if (tick_count !== 32'd0) begin n_err++; $display("FAIL rp_tick_count got %0d exp 0", tick_count); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rp_out_valid got %b exp 0", out_valid); end
        rst = 1'b0;
        cyc();
        n_vec++; if (step_ready !== 1'b1) begin n_err++; $display("FAIL rp_step_ready got %b exp 1", step_ready); end
        issue_step(16'd1);
        repeat (8) cyc();
        n_vec++; if (tick_count !== 32'd1) begin n_err++; $display("FAIL rp_new_step_count got %0d exp 1", tick_count); end
        n_vec++; if (out_data !== 8'hFF) begin n_err++; $display("FAIL rp_new_step_data got %h exp ff", out_data); end
    endtask

    initial begin
        test_reset();
        test_step();
        test_pending();
        test_backpressure();
        test_run();
        test_zero_step();
        test_wrap();
        test_reset_in_pulse();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
